// File: rtl/ram_pkg.sv
// Shared constants and reciprocal-seed table helpers for the dual-bank RAM.
package ram_pkg;

    localparam int unsigned RAM_DEPTH = 1024;
    localparam int unsigned RAM_AW    = 10;
    localparam int unsigned RAM_DW    = 24;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_e;

    typedef struct packed {
        logic [RAM_DW-1:0] x0;
        logic [RAM_DW-1:0] x1;
    } seed_t;

    typedef logic [RAM_DEPTH-1:0][RAM_DW-1:0] mem_t;

    // x0 is the midpoint of 2^46/d over the interval [1024+i, 1025+i) scaled by 4096; x1 = x0^2 >> 24.
    function automatic seed_t calc_seed(input int unsigned idx);
        longint unsigned num;
        longint unsigned d0;
        longint unsigned d1;
        longint unsigned x0;
        longint unsigned sq;
        seed_t           s;
        num  = 64'd1 << 46;
        d0   = (64'd1024 + 64'(idx)) * 64'd4096;
        d1   = (64'd1025 + 64'(idx)) * 64'd4096;
        x0   = ((num / d0) + (num / d1)) >> 1;
        sq   = (x0 * x0) >> 24;
        s.x0 = x0[RAM_DW-1:0];
        s.x1 = sq[RAM_DW-1:0];
        return s;
    endfunction

    function automatic mem_t init_table(input bank_sel_e sel);
        mem_t  t;
        seed_t s;
        for (int unsigned i = 0; i < RAM_DEPTH; i++) begin
            s    = calc_seed(i);
            t[i] = (sel == BANK_A) ? s.x1 : s.x0;
        end
        return t;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One 1024x24 bank: synchronous write, registered read, seeded power-up contents.
// RAM_WRITE_FIRST_EN selects write-through on the read port; default is read-first.
module ram_bank
    import ram_pkg::*;
#(
    parameter bank_sel_e SEL = BANK_A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [RAM_DW-1:0] din,
    output logic [RAM_DW-1:0] dout
);

    mem_t mem = init_table(SEL);

    // Memory has no reset so the table survives; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
`ifdef RAM_WRITE_FIRST_EN
            if (we) begin
                dout <= din;
            end else begin
                dout <= mem[addr];
            end
`else
            dout <= mem[addr];
`endif
        end
    end

endmodule

// File: rtl/ram.sv
// Dual-bank 1024x24 reciprocal-seed RAM sharing one address and write enable.
// RAM_WRITE_FIRST_EN (in ram_bank) switches both banks to write-through reads.
module ram
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RAM_AW-1:0] addr,
    input  logic [RAM_DW-1:0] in_a,
    input  logic [RAM_DW-1:0] in_b,
    output logic [RAM_DW-1:0] a,
    output logic [RAM_DW-1:0] b
);

    logic [RAM_DW-1:0] din  [2];
    logic [RAM_DW-1:0] dout [2];

    assign din[0] = in_a;
    assign din[1] = in_b;
    assign a      = dout[0];
    assign b      = dout[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        ram_bank #(
            .SEL ((gi == 0) ? BANK_A : BANK_B)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (load),
            .addr  (addr),
            .din   (din[gi]),
            .dout  (dout[gi])
        );
    end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for the dual-bank RAM: independent table model plus write tracking.
module tb_ram;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [9:0]  addr;
    logic [23:0] in_a;
    logic [23:0] in_b;
    logic [23:0] a;
    logic [23:0] b;

    logic [23:0] mod_a [1024];
    logic [23:0] mod_b [1024];
    logic [47:0] exp_q [$];

    int checks;
    int errors;

    ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .addr  (addr),
        .in_a  (in_a),
        .in_b  (in_b),
        .a     (a),
        .b     (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %06h want %06h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, record the expected read, then sample 1 ns after the edge.
    task automatic cycle(input logic l, input logic [9:0] ad, input logic [23:0] ia,
                         input logic [23:0] ib, input string tag);
        logic [47:0] e;
        load = l;
        addr = ad;
        in_a = ia;
        in_b = ib;
`ifdef RAM_WRITE_FIRST_EN
        e = l ? {ia, ib} : {mod_a[ad], mod_b[ad]};
`else
        e = {mod_a[ad], mod_b[ad]};
`endif
        exp_q.push_back(e);
        if (l) begin
            mod_a[ad] = ia;
            mod_b[ad] = ib;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("%s_a@%0d", tag, ad), a, e[47:24]);
        check($sformatf("%s_b@%0d", tag, ad), b, e[23:0]);
        $display("txn %s load=%0b addr=%0d a=%06h b=%06h", tag, l, ad, a, b);
    endtask

    initial begin
        longint unsigned num, x0, sq;
        checks = 0;
        errors = 0;
        num = 64'd1 << 46;
        for (int i = 0; i < 1024; i++) begin
            x0 = ((num / ((64'd1024 + 64'(i)) * 64'd4096)) +
                  (num / ((64'd1025 + 64'(i)) * 64'd4096))) / 64'd2;
            sq = (x0 * x0) >> 24;
            mod_b[i] = x0[23:0];
            mod_a[i] = sq[23:0];
        end

        rst_n = 1'b0;
        load  = 1'b0;
        addr  = '0;
        in_a  = '0;
        in_b  = '0;
        #3;
        check("rst_a", a, 24'h0);
        check("rst_b", b, 24'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle(1'b0, 10'd0, 24'h0, 24'h0, "first");
        check("lit_a0", a, 24'hFFC011);
        check("lit_b0", b, 24'hFFE007);
        cycle(1'b0, 10'd1023, 24'h0, 24'h0, "top");
        check("lit_a1023", a, 24'h400801);
        check("lit_b1023", b, 24'h800801);

        for (int i = 0; i < 1024; i++) begin
            cycle(1'b0, 10'(i), 24'(i * 7), 24'(i * 13), "sweep");
        end

        cycle(1'b1, 10'd5, 24'h123456, 24'hABCDEF, "wr5");
        cycle(1'b0, 10'd5, 24'h0, 24'h0, "rd5");
        check("lit_a5", a, 24'h123456);
        check("lit_b5", b, 24'hABCDEF);

        cycle(1'b0, 10'd7, 24'h555555, 24'hAAAAAA, "noload7");
        cycle(1'b0, 10'd7, 24'h0, 24'h0, "rd7");

        cycle(1'b0, 10'd0, 24'h0, 24'h0, "b2b");
        cycle(1'b0, 10'd1, 24'h0, 24'h0, "b2b");
        cycle(1'b0, 10'd2, 24'h0, 24'h0, "b2b");

        // Reset mid-stream: outputs clear without a clock and a write under reset is dropped.
        cycle(1'b0, 10'd1, 24'h0, 24'h0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_a", a, 24'h0);
        check("midrst_b", b, 24'h0);
        load = 1'b1;
        addr = 10'd5;
        in_a = 24'h111111;
        in_b = 24'h222222;
        @(posedge clk);
        #1;
        check("inrst_a", a, 24'h0);
        check("inrst_b", b, 24'h0);
        load  = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 10'd5, 24'h0, 24'h0, "post_rst");
        check("keep_a5", a, 24'h123456);
        check("keep_b5", b, 24'hABCDEF);

        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
                  24'($urandom), 24'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port load, input, 1 bit: write enable for both banks.
REQ-004 SHALL have port addr, input, 10 bits: shared read/write address, 0..1023.
REQ-005 SHALL have port in_a, input, 24 bits: write data for bank A.
REQ-006 SHALL have port in_b, input, 24 bits: write data for bank B.
REQ-007 SHALL have port a, output, 24 bits: registered read data from bank A.
REQ-008 SHALL have port b, output, 24 bits: registered read data from bank B.

Function
REQ-009 SHALL contain two 1024x24 banks, A and B, addressed by the same addr.
REQ-010 SHALL write in_a to A[addr] and in_b to B[addr] on a clk rising edge when load=1.
REQ-011 SHALL leave memory unchanged when load=0.
REQ-012 SHALL register A[addr] into a and B[addr] into b on every clk rising edge, whatever the value of load; read latency is 1 cycle.
REQ-013 SHALL return the pre-write (old) contents on a, b when load=1 and a read hit the same addr in one cycle (read-first), unless RAM_WRITE_FIRST_EN is defined.
REQ-014 SHALL hold power-up contents of reciprocal-seed values for i = 0..1023, computed with 64-bit unsigned integer math and floor division:
- x0 = ((2^46 / ((1024+i)*4096)) + (2^46 / ((1025+i)*4096))) / 2
- B[i] = x0[23:0]
- A[i] = ((x0*x0) >> 24)[23:0]
REQ-015 SHALL preserve table values at A[0]=0xFFC011, B[0]=0xFFE007, A[1023]=0x400801, B[1023]=0x800801.
REQ-016 SHALL treat every addr value as valid; there is no out-of-range case and no wrap logic.

Reset
REQ-017 SHALL clear a and b to 24'h0 asynchronously while rst_n=0.
REQ-018 SHALL NOT alter memory contents on reset; the table survives reset.
REQ-019 SHALL ignore load while rst_n=0 (no write).
REQ-020 SHALL produce valid read data on a, b one clk edge after rst_n deasserts.

Configuration
REQ-021 SHALL support macro RAM_WRITE_FIRST_EN; when it is defined and load=1, a and b SHALL be loaded with in_a and in_b on that same edge (write-through).
REQ-022 SHALL behave as read-first per REQ-013 when RAM_WRITE_FIRST_EN is undefined.

Structure
REQ-023 SHALL place constants RAM_DEPTH=1024, RAM_AW=10 and RAM_DW=24, plus a function computing (x0, x1) for an index, in shared package ram_pkg.
REQ-024 SHALL build each bank as one instance of sub-module ram_bank (1024x24, sync write, registered read, parameterised init select A or B), instantiated twice.

Verification
REQ-025 SHALL cover: reset release, load=0, addr=0 -> next cycle a=0xFFC011, b=0xFFE007.
REQ-026 SHALL cover: load=0, addr=1023 -> next cycle a=0x400801, b=0x800801; all 1024 entries match the REQ-014 model.
REQ-027 SHALL cover: load=1, addr=5, in_a=0x123456, in_b=0xABCDEF -> a and b show old table values that cycle (read-first); a read of addr=5 then returns 0x123456 / 0xABCDEF.
REQ-028 SHALL cover: same write with RAM_WRITE_FIRST_EN defined -> a=0x123456, b=0xABCDEF on the write edge.
REQ-029 SHALL cover: rst_n pulled low mid-stream -> a=b=0 immediately without a clock; written entry at addr=5 still reads 0x123456 after release.
REQ-030 SHALL cover: back-to-back reads of addr 0,1,2 -> outputs track with exactly 1-cycle latency.
